button_debounce: RTL and testbench

Multi-channel push-button input conditioner for the iCE40HX8K board designs: synchronises raw button pins into the `hwclk` domain, debounces each channel, and emits clean levels plus single-cycle press/release pulses. It also keeps a wrapping press-event counter that top-level designs can drive straight onto the eight board LEDs. It is the input-side counterpart to the LED output path, and replaces ad-hoc counter-driven logic wherever user input is needed.

---
 rtl/button_debounce.sv | 84 ++++++++
 tb/tb_button_debounce.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, per-channel debounce,
// press/release pulses and a wrapping press-event counter.
module button_debounce #(
    parameter int W          = 4,
    parameter int DB_CYCLES  = 120000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         hwclk,
    input  logic         rst_n,
    input  logic [W-1:0] btn_raw,
    input  logic         cnt_clr,
    output logic [W-1:0] btn_level,
    output logic [W-1:0] btn_press,
    output logic [W-1:0] btn_release,
    output logic [7:0]   press_cnt
);

    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [W-1:0]  norm;
    logic [W-1:0]  s1_q, s2_q;
    logic [W-1:0]  level_q, level_d;
    logic [W-1:0]  press_q, release_q;
    logic [W-1:0]  press_now, release_now;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];
    logic [7:0]    press_cnt_q, press_cnt_d, press_sum;

    // Normalise so that 1 always means "pressed" before synchronising.
    assign norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_comb begin
        level_d     = level_q;
        press_now   = '0;
        release_now = '0;
        press_sum   = '0;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]     = s2_q[i];
                    press_now[i]   = s2_q[i];
                    release_now[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            press_sum = press_sum + {7'd0, press_now[i]};
        end
        // Clear takes effect first so same-edge presses are still counted.
        press_cnt_d = (cnt_clr ? 8'd0 : press_cnt_q) + press_sum;
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            press_cnt_q <= '0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q        <= norm;
            s2_q        <= s1_q;
            level_q     <= level_d;
            press_q     <= press_now;
            release_q   <= release_now;
            press_cnt_q <= press_cnt_d;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: an active-low and an active-high instance see
// logically identical stimulus and must give identical, expected responses.
module tb_button_debounce;

    logic       hwclk;
    logic       rst_n;
    logic       cnt_clr;
    logic [3:0] pressed;
    logic [3:0] btn_raw_a, btn_raw_b;
    logic [3:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
    logic [7:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected event: {cycle[15:0], level, press, release, press_cnt}
    logic [35:0] exp_q[$];
    logic [3:0]  exp_level = '0;
    logic [7:0]  exp_cnt   = '0;

    assign btn_raw_a = ~pressed;
    assign btn_raw_b = pressed;

    button_debounce #(.W(4), .DB_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
        .hwclk(hwclk), .rst_n(rst_n), .btn_raw(btn_raw_a), .cnt_clr(cnt_clr),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .press_cnt(cnt_a)
    );

    button_debounce #(.W(4), .DB_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_b (
        .hwclk(hwclk), .rst_n(rst_n), .btn_raw(btn_raw_b), .cnt_clr(cnt_clr),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .press_cnt(cnt_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        hwclk = 1'b0;
        forever #5 hwclk = ~hwclk;
    end

    always @(posedge hwclk) cyc = cyc + 1;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_a"}, 64'({lvl_a, prs_a, rel_a, cnt_a}), 64'd0);
        check_eq({tag, "_b"}, 64'({lvl_b, prs_b, rel_b, cnt_b}), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge hwclk) begin : monitor
        logic [35:0] e;
        if (exp_q.size() > 0 && exp_q[0][35:20] < 16'(cyc)) begin
            e = exp_q.pop_front();
            check_eq("event_timeout", 64'(cyc), 64'(e[35:20]));
        end
        if ((prs_a | rel_a | prs_b | rel_b) != 4'd0) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_pulse", 64'({prs_a, rel_a, prs_b, rel_b}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("event_cycle", 64'(cyc), 64'(e[35:20]));
                check_eq("event_a", 64'({lvl_a, prs_a, rel_a, cnt_a}), 64'(e[19:0]));
                check_eq("event_b", 64'({lvl_b, prs_b, rel_b, cnt_b}), 64'(e[19:0]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(negedge hwclk);
    endtask

    task automatic expect_event(input logic [3:0] press_m, input logic [3:0] rel_m, input logic clr);
        exp_level = (exp_level | press_m) & ~rel_m;
        exp_cnt   = (clr ? 8'd0 : exp_cnt) + 8'($countones(press_m));
        exp_q.push_back({16'(cyc + 6), exp_level, press_m, rel_m, exp_cnt});
    endtask

    // Change the pressed set and expect the matching accepted transition
    // DB_CYCLES+2 edges later; optionally raise cnt_clr on the accepting edge.
    task automatic act(input logic [3:0] new_p, input logic clr_on_accept);
        logic [3:0] old_p;
        step();
        old_p   = pressed;
        pressed = new_p;
        expect_event(new_p & ~old_p, old_p & ~new_p, clr_on_accept);
        if (clr_on_accept) begin
            repeat (5) step();
            cnt_clr = 1'b1;
            step();
            cnt_clr = 1'b0;
            repeat (2) step();
        end else begin
            repeat (8) step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        cnt_clr = 1'b0;
        pressed = 4'b0000;
        repeat (3) step();
        check_all_zero("reset_state");
        rst_n = 1'b1;

        // Clean press and release on channel 0.
        act(4'b0001, 1'b0);
        check_eq("clean_hold_level", 64'(lvl_a), 64'd1);
        act(4'b0000, 1'b0);
        check_eq("clean_cnt_after_release", 64'(cnt_a), 64'd1);

        // Bounce on channel 1: 3 pressed, 1 released, 3 pressed, released.
        step();
        pressed = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 7) pressed = 4'b0000;
            if (i == 4) pressed = 4'b0010;
            step();
            check_eq("bounce_level", 64'({lvl_a[1], lvl_b[1]}), 64'd0);
        end
        check_eq("bounce_cnt", 64'({cnt_a, cnt_b}), 64'({8'd1, 8'd1}));

        // Simultaneous press of channels 0, 2, 3.
        act(4'b1101, 1'b0);
        act(4'b0000, 1'b0);

        // Accumulate presses to 254, then wrap with a three-channel press.
        for (int i = 0; i < 62; i++) begin
            act(4'b1111, 1'b0);
            act(4'b0000, 1'b0);
        end
        act(4'b0011, 1'b0);
        act(4'b0000, 1'b0);
        check_eq("pre_wrap_cnt", 64'(cnt_a), 64'd254);
        act(4'b1101, 1'b0);
        act(4'b0000, 1'b0);

        // Reach 9, then clear on the same edge channel 1's press is accepted.
        act(4'b1111, 1'b0);
        act(4'b0000, 1'b0);
        act(4'b1111, 1'b0);
        act(4'b0000, 1'b0);
        check_eq("pre_clear_cnt", 64'(cnt_b), 64'd9);
        act(4'b0010, 1'b1);
        act(4'b0000, 1'b0);

        // Reset while channel 2 is mid-debounce (its counter at 2).
        step();
        pressed = 4'b0100;
        repeat (4) step();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("in_reset");
        end
        rst_n     = 1'b1;
        exp_level = '0;
        exp_cnt   = '0;
        expect_event(4'b0100, 4'b0000, 1'b0);
        repeat (8) step();
        act(4'b0000, 1'b0);

        repeat (4) step();
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
        check_eq("final_cnt", 64'({cnt_a, cnt_b}), 64'({8'd1, 8'd1}));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
